// File: rtl/y_window_3x3.sv
// 3x3 luma neighbourhood generator: two line buffers feed a 3x3 tap array, valid 1 clk after each pixel.
// Optional macro WINDOW_BORDER_ZERO_EN zeroes taps that fall above or left of the frame.
module y_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    input  logic              din_hsync,
    input  logic              din_vsync,
    output logic [DATA_W-1:0] matrix_11,
    output logic [DATA_W-1:0] matrix_12,
    output logic [DATA_W-1:0] matrix_13,
    output logic [DATA_W-1:0] matrix_21,
    output logic [DATA_W-1:0] matrix_22,
    output logic [DATA_W-1:0] matrix_23,
    output logic [DATA_W-1:0] matrix_31,
    output logic [DATA_W-1:0] matrix_32,
    output logic [DATA_W-1:0] matrix_33,
    output logic              mat_vld,
    output logic              mat_hsync,
    output logic              mat_vsync,
    output logic              line_ovf
);

    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 1);

    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] lb2_mem [IMG_W];
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] lb2_rd;

    // tap_q[row][col]: row 0 is the oldest line, col 2 the newest pixel
    logic [2:0][2:0][DATA_W-1:0] tap_q, tap_d;
    logic [2:0][DATA_W-1:0]      new_row;
    logic                        col_zero;

    logic [ADDR_W-1:0] col_cnt_q, col_cnt_d;
    logic [1:0]        row_cnt_q, row_cnt_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic              vld_q, hsync_q, vsync_q;
    logic              vs_rise, line_end, wr_en;

    assign lb1_rd   = lb1_mem[col_cnt_q];
    assign lb2_rd   = lb2_mem[col_cnt_q];
    assign vs_rise  = din_vsync & ~vsync_q;
    assign line_end = vld_q & ~din_vld;
    // sat_q marks that column IMG_W-1 has already been written on this line
    assign wr_en    = din_vld & ~sat_q & ~rst;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        new_row[2] = din;
        new_row[1] = lb1_rd;
        new_row[0] = lb2_rd;
        col_zero   = 1'b0;
`ifdef WINDOW_BORDER_ZERO_EN
        if (row_cnt_q == 2'd0) begin
            new_row[1] = '0;
            new_row[0] = '0;
        end else if (row_cnt_q == 2'd1) begin
            new_row[0] = '0;
        end
        col_zero = (col_cnt_q == '0);
`endif
        tap_d = tap_q;
        if (din_vld) begin
            for (int r = 0; r < 3; r++) begin
                tap_d[r][0] = col_zero ? '0 : tap_q[r][1];
                tap_d[r][1] = col_zero ? '0 : tap_q[r][2];
                tap_d[r][2] = new_row[r];
            end
        end
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        sat_d     = sat_q;
        ovf_d     = ovf_q;
        if (din_vld) begin
            if (sat_q) begin
                ovf_d = 1'b1;
            end else if (col_cnt_q == COL_MAX) begin
                sat_d = 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + ADDR_W'(1);
            end
        end
        if (line_end) begin
            col_cnt_d = '0;
            sat_d     = 1'b0;
            row_cnt_d = (row_cnt_q == 2'd2) ? 2'd2 : row_cnt_q + 2'd1;
        end
        // a new frame overrides any coincident line end
        if (vs_rise) begin
            col_cnt_d = '0;
            row_cnt_d = '0;
            sat_d     = 1'b0;
            ovf_d     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q     <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
            vld_q     <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
        end else begin
            tap_q     <= tap_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
            vld_q     <= din_vld;
            hsync_q   <= din_hsync;
            vsync_q   <= din_vsync;
        end
    end

    // NOTE: line-buffer RAM has no reset; stale contents are either masked or passed as border data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb1_mem[col_cnt_q] <= din;
            lb2_mem[col_cnt_q] <= lb1_rd;
        end
    end

    assign matrix_11 = tap_q[0][0];
    assign matrix_12 = tap_q[0][1];
    assign matrix_13 = tap_q[0][2];
    assign matrix_21 = tap_q[1][0];
    assign matrix_22 = tap_q[1][1];
    assign matrix_23 = tap_q[1][2];
    assign matrix_31 = tap_q[2][0];
    assign matrix_32 = tap_q[2][1];
    assign matrix_33 = tap_q[2][2];
    assign mat_vld   = vld_q;
    assign mat_hsync = hsync_q;
    assign mat_vsync = vsync_q;
    assign line_ovf  = ovf_q;

endmodule

// File: tb/tb_y_window_3x3.sv
// Bench for y_window_3x3 (IMG_W=4): random frames checked against an image-level window model.
// Expectations follow WINDOW_BORDER_ZERO_EN the same way the design build does.
module tb_y_window_3x3;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              din_vld;
    logic [DATA_W-1:0] din;
    logic              din_hsync;
    logic              din_vsync;
    logic [DATA_W-1:0] matrix_11, matrix_12, matrix_13;
    logic [DATA_W-1:0] matrix_21, matrix_22, matrix_23;
    logic [DATA_W-1:0] matrix_31, matrix_32, matrix_33;
    logic              mat_vld, mat_hsync, mat_vsync, line_ovf;

    y_window_3x3 #(.DATA_W(DATA_W), .IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din),
        .din_hsync(din_hsync), .din_vsync(din_vsync),
        .matrix_11(matrix_11), .matrix_12(matrix_12), .matrix_13(matrix_13),
        .matrix_21(matrix_21), .matrix_22(matrix_22), .matrix_23(matrix_23),
        .matrix_31(matrix_31), .matrix_32(matrix_32), .matrix_33(matrix_33),
        .mat_vld(mat_vld), .mat_hsync(mat_hsync), .mat_vsync(mat_vsync),
        .line_ovf(line_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Image model: img holds the current frame as written to RAM, prev the previous full frame
    logic [7:0] img  [8][IMG_W];
    logic [7:0] prev [8][IMG_W];
    int         nrows;
    int         prev_h;
    bit         prev_valid;
    bit         cur_full;
    logic [7:0] last_px;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] get_tap(input int i, input int j);
        case (i * 3 + j)
            0: return matrix_11;
            1: return matrix_12;
            2: return matrix_13;
            3: return matrix_21;
            4: return matrix_22;
            5: return matrix_23;
            6: return matrix_31;
            7: return matrix_32;
            default: return matrix_33;
        endcase
    endfunction

    // Window tap (i,j) after pixel (r,c) is image pixel (r-2+i, c-2+j); returns 0 if not predictable
    function automatic bit exp_tap(input int r, input int c, input int i, input int j,
                                   output logic [7:0] v);
        int rr;
        int cc;
        rr = r - 2 + i;
        cc = c - 2 + j;
        v  = 8'h00;
`ifdef WINDOW_BORDER_ZERO_EN
        if (rr < 0 || cc < 0) return 1'b1;
        v = img[rr][cc];
        return 1'b1;
`else
        if (cc < 0) return 1'b0;
        if (rr >= 0) begin
            v = img[rr][cc];
            return 1'b1;
        end
        if (!prev_valid) return 1'b0;
        v = prev[prev_h + rr][cc];
        return 1'b1;
`endif
    endfunction

    task automatic send_pixel(input int c, input logic [7:0] v);
        int         r;
        logic [7:0] e;
        r = nrows;
        if (c < IMG_W) img[r][c] = v;
        din       = v;
        din_vld   = 1'b1;
        din_hsync = 1'b1;
        tick();
        last_px = v;
        n_checks++;
        if (mat_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL mat_vld r%0d c%0d: got %b exp 1", r, c, mat_vld);
        end
        if (c < IMG_W) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    if (exp_tap(r, c, i, j, e)) begin
                        n_checks++;
                        if (get_tap(i, j) !== e) begin
                            n_fail++;
                            $display("FAIL window r%0d c%0d m%0d%0d: got %h exp %h",
                                     r, c, i + 1, j + 1, get_tap(i, j), e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic end_line(input int len);
        din_vld   = 1'b0;
        din_hsync = 1'b0;
        tick();
        n_checks++;
        if (matrix_33 !== last_px) begin
            n_fail++;
            $display("FAIL tap_hold: got %h exp %h", matrix_33, last_px);
        end
        nrows++;
        if (len < IMG_W) cur_full = 1'b0;
    endtask

    task automatic send_rand_line(input int len);
        for (int c = 0; c < len; c++) send_pixel(c, 8'($urandom_range(0, 255)));
        end_line(len);
    endtask

    task automatic new_frame();
        if (nrows >= 2 && cur_full) begin
            prev       = img;
            prev_h     = nrows;
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
        nrows    = 0;
        cur_full = 1'b1;
        din_vld   = 1'b0;
        din_vsync = 1'b1;
        tick();
        n_checks++;
        if (mat_vsync !== 1'b1) begin
            n_fail++;
            $display("FAIL mat_vsync_pulse: got %b exp 1", mat_vsync);
        end
        din_vsync = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] first;
        rst = 1'b1;
        din_vld = 1'b0; din_hsync = 1'b0; din_vsync = 1'b0; din = '0;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            din = 8'($urandom_range(1, 255)); din_vld = 1'b1; din_hsync = 1'b1;
            tick();
        end
        rst = 1'b1; din_vsync = 1'b1; din = 8'hFF;
        for (int k = 0; k < 3; k++) tick();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (get_tap(i, j) !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_tap m%0d%0d: got %h exp 00", i + 1, j + 1, get_tap(i, j));
                end
            end
        end
        n_checks++;
        if ({mat_vld, mat_hsync, mat_vsync, line_ovf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b exp 0000", {mat_vld, mat_hsync, mat_vsync, line_ovf});
        end
        rst = 1'b0; din_vld = 1'b0; din_hsync = 1'b0; din_vsync = 1'b0;
        tick();
        nrows = 0; prev_valid = 1'b0; cur_full = 1'b1;
        send_rand_line(IMG_W);
        first = img[0][0];
        send_pixel(0, 8'($urandom_range(0, 255)));
        n_checks++;
        if (matrix_23 !== first) begin
            n_fail++;
            $display("FAIL reset_col0: got %h exp %h", matrix_23, first);
        end
        for (int c = 1; c < IMG_W; c++) send_pixel(c, 8'($urandom_range(0, 255)));
        end_line(IMG_W);
    endtask

    task automatic test_frame();
        logic [7:0] k [9];
        k = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        new_frame();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < IMG_W; c++) send_pixel(c, 8'(r * 16 + c));
            end_line(IMG_W);
        end
        for (int c = 0; c < 3; c++) send_pixel(c, 8'(32 + c));
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (get_tap(i, j) !== k[i * 3 + j]) begin
                    n_fail++;
                    $display("FAIL frame_2_2 m%0d%0d: got %h exp %h",
                             i + 1, j + 1, get_tap(i, j), k[i * 3 + j]);
                end
            end
        end
        send_pixel(3, 8'h23);
        end_line(IMG_W);
        for (int c = 0; c < IMG_W; c++) send_pixel(c, 8'(48 + c));
        end_line(IMG_W);
        for (int f = 0; f < 2; f++) begin
            int h;
            h = int'($urandom_range(2, 5));
            new_frame();
            for (int r = 0; r < h; r++) send_rand_line(IMG_W);
        end
    endtask

    task automatic test_border();
        logic [7:0] e;
        new_frame();
        send_pixel(0, 8'h55);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
`ifdef WINDOW_BORDER_ZERO_EN
                e = (i == 2 && j == 2) ? 8'h55 : 8'h00;
                n_checks++;
                if (get_tap(i, j) !== e) begin
                    n_fail++;
                    $display("FAIL border m%0d%0d: got %h exp %h", i + 1, j + 1, get_tap(i, j), e);
                end
`else
                if (i == 0 && j == 2 && prev_valid) begin
                    e = prev[prev_h - 2][0];
                    n_checks++;
                    if (matrix_13 !== e) begin
                        n_fail++;
                        $display("FAIL border_raw m13: got %h exp %h", matrix_13, e);
                    end
                end
`endif
            end
        end
        for (int c = 1; c < IMG_W; c++) send_pixel(c, 8'($urandom_range(0, 255)));
        end_line(IMG_W);
        send_rand_line(IMG_W);
        send_rand_line(IMG_W);
    endtask

    task automatic test_vsync_restart();
        logic [7:0] e;
        new_frame();
        for (int r = 0; r < 3; r++) send_rand_line(IMG_W);
        new_frame();
        send_pixel(0, 8'($urandom_range(0, 255)));
`ifdef WINDOW_BORDER_ZERO_EN
        e = 8'h00;
`else
        e = prev[prev_h - 1][0];
`endif
        n_checks++;
        if (matrix_23 !== e) begin
            n_fail++;
            $display("FAIL vsync_restart m23: got %h exp %h", matrix_23, e);
        end
        for (int c = 1; c < IMG_W; c++) send_pixel(c, 8'($urandom_range(0, 255)));
        end_line(IMG_W);
        send_rand_line(IMG_W);
    endtask

    task automatic test_overflow();
        logic [7:0] p [6];
        for (int c = 0; c < 6; c++) p[c] = 8'($urandom_range(0, 255));
        new_frame();
        for (int c = 0; c < 6; c++) begin
            send_pixel(c, p[c]);
            if (c >= 3) begin
                n_checks++;
                if (line_ovf !== (c >= 4)) begin
                    n_fail++;
                    $display("FAIL line_ovf pixel%0d: got %b exp %b", c + 1, line_ovf, c >= 4);
                end
            end
        end
        end_line(6);
        for (int c = 0; c < IMG_W; c++) send_pixel(c, 8'($urandom_range(0, 255)));
        n_checks++;
        if (matrix_23 !== p[3]) begin
            n_fail++;
            $display("FAIL ovf_ram_col3: got %h exp %h", matrix_23, p[3]);
        end
        end_line(IMG_W);
        n_checks++;
        if (line_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b exp 1", line_ovf);
        end
        new_frame();
        n_checks++;
        if (line_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b exp 0", line_ovf);
        end
    endtask

    task automatic test_sync();
        logic [2:0] sent;
        for (int k = 0; k < 200; k++) begin
            sent      = 3'($urandom_range(0, 7));
            din_vld   = sent[2];
            din_hsync = sent[1];
            din_vsync = sent[0];
            din       = 8'($urandom_range(0, 255));
            tick();
            n_checks++;
            if ({mat_vld, mat_hsync, mat_vsync} !== sent) begin
                n_fail++;
                $display("FAIL sync_delay cycle%0d: got %b exp %b", k,
                         {mat_vld, mat_hsync, mat_vsync}, sent);
            end
        end
        din_vld = 1'b0; din_hsync = 1'b0; din_vsync = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_border();
        test_vsync_restart();
        test_overflow();
        test_sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
